// File: rtl/bit_matvec_engine_if.sv
// Handshake bundle for bit_matvec_engine: row-load port, vector port, result port.
// The master side drives requests and res_ready; the slave side is the engine.
interface bit_matvec_engine_if #(
  parameter int N  = 6,
  parameter int RW = $clog2(N)
);
  logic          load_valid;
  logic          load_ready;
  logic [N-1:0]  load_data;
  logic          load_clr;
  logic [RW-1:0] load_row;
  logic          vec_valid;
  logic          vec_ready;
  logic [N-1:0]  vec_data;
  logic          vec_mode;
  logic          res_valid;
  logic          res_ready;
  logic [N-1:0]  res_data;
  logic          busy;

  modport master (
    output load_valid, load_data, load_clr, vec_valid, vec_data, vec_mode, res_ready,
    input  load_ready, load_row, vec_ready, res_valid, res_data, busy
  );

  modport slave (
    input  load_valid, load_data, load_clr, vec_valid, vec_data, vec_mode, res_ready,
    output load_ready, load_row, vec_ready, res_valid, res_data, busy
  );
endinterface

// File: rtl/bit_matvec_engine.sv
// N x N bit-matrix times N-bit vector, one matrix row folded per cycle,
// XOR (GF(2)) or OR accumulation; result held on a valid/ready port.

// One result column: folds the selected row's bit into the accumulator.
module bmv_lane (
  input  logic term_i,
  input  logic mode_i,
  input  logic acc_i,
  output logic acc_o
);
  assign acc_o = mode_i ? (acc_i | term_i) : (acc_i ^ term_i);
endmodule

module bit_matvec_engine #(
  parameter int N  = 6,
  parameter int RW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bit_matvec_engine_if.slave   io
);
  localparam logic [1:0]    S_IDLE    = 2'd0;
  localparam logic [1:0]    S_COMPUTE = 2'd1;
  localparam logic [1:0]    S_DONE    = 2'd2;
  localparam logic [RW-1:0] LAST      = RW'(N-1);

  logic [1:0]          state_q, state_d;
  logic [N-1:0][N-1:0] mat_q, mat_d;
  logic [RW-1:0]       load_row_q, load_row_d;
  logic [RW-1:0]       k_q, k_d;
  logic [N-1:0]        x_q, x_d;
  logic [N-1:0]        acc_q, acc_d;
  logic [N-1:0]        res_data_q, res_data_d;
  logic                mode_q, mode_d;
  logic                res_valid_q, res_valid_d;
  logic [N-1:0]        row_term, acc_nxt;
  logic                load_fire, vec_fire;

  // Row k contributes only when x[k] is set.
  assign row_term = x_q[k_q] ? mat_q[k_q] : '0;

  for (genvar j = 0; j < N; j++) begin : g_lane
    bmv_lane u_lane (
      .term_i (row_term[j]),
      .mode_i (mode_q),
      .acc_i  (acc_q[j]),
      .acc_o  (acc_nxt[j])
    );
  end

  // Readies come from state and load_valid only, never from res_ready.
  assign io.load_ready = (state_q == S_IDLE);
  assign io.vec_ready  = (state_q == S_IDLE) & ~io.load_valid;
  assign load_fire     = io.load_ready & io.load_valid;
  assign vec_fire      = io.vec_ready & io.vec_valid;

  assign io.load_row  = load_row_q;
  assign io.res_valid = res_valid_q;
  assign io.res_data  = res_data_q;
  assign io.busy      = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    mat_d       = mat_q;
    load_row_d  = load_row_q;
    k_d         = k_q;
    x_d         = x_q;
    acc_d       = acc_q;
    mode_d      = mode_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;

    // A clear riding on a load writes row 0 and leaves the pointer at row 1.
    if (load_fire) begin
      if (io.load_clr) begin
        mat_d[0]   = io.load_data;
        load_row_d = RW'(1);
      end else begin
        mat_d[load_row_q] = io.load_data;
        load_row_d        = (load_row_q == LAST) ? '0 : load_row_q + 1'b1;
      end
    end else if (io.load_clr) begin
      load_row_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (vec_fire) begin
          x_d     = io.vec_data;
          mode_d  = io.vec_mode;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        acc_d = acc_nxt;
        if (k_q == LAST) begin
          k_d         = '0;
          res_data_d  = acc_nxt;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        if (io.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mat_q       <= '0;
      load_row_q  <= '0;
      k_q         <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      mode_q      <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mat_q       <= mat_d;
      load_row_q  <= load_row_d;
      k_q         <= k_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end
endmodule

// File: tb/tb_bit_matvec_engine.sv
// Bench for bit_matvec_engine (N=6): table of vectors on identity / all-ones
// matrices, hand sequences for pointer wrap, load/vector collision, backpressure, reset.
module tb_bit_matvec_engine;
  localparam int N = 6;

  typedef struct packed {
    logic       ident;
    logic [5:0] vec;
    logic       mode;
    logic [5:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_app = 0;
  int   n_err = 0;
  logic [5:0] sb [$];
  logic [5:0] m [N];
  int   ptr = 0;
  vec_t tbl [8];

  bit_matvec_engine_if #(.N(N)) io ();
  bit_matvec_engine #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_app++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] mv(input logic [5:0] x, input logic md);
    logic [5:0] y = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (x[i] && m[i][j]) y[j] = md ? 1'b1 : ~y[j];
    return y;
  endfunction

  // Scoreboard: pop on every result handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && io.res_valid && io.res_ready) begin
        if (sb.size() == 0) begin
          n_app++;
          n_err++;
          $display("FAIL res_unexpected: got %b expected none", io.res_data);
        end else begin
          check("res_data", 16'(io.res_data), 16'(sb.pop_front()));
        end
      end
    end
  end

  task automatic do_load(input logic [5:0] d, input logic clr);
    @(negedge clk);
    io.load_valid = 1'b1;
    io.load_data  = d;
    io.load_clr   = clr;
    @(negedge clk);
    io.load_valid = 1'b0;
    io.load_clr   = 1'b0;
    if (clr) begin m[0] = d; ptr = 1; end
    else begin m[ptr] = d; ptr = (ptr == N-1) ? 0 : ptr + 1; end
  endtask

  task automatic load_matrix(input logic ones);
    for (int i = 0; i < N; i++) do_load(ones ? 6'h3F : 6'(1 << i), 1'b0);
  endtask

  task automatic wait_ready;
    int c = 0;
    #1;
    while (!io.vec_ready && c < 40) begin @(negedge clk); #1; c++; end
    if (c >= 40) check("vec_ready_timeout", 16'(io.vec_ready), 16'd1);
  endtask

  task automatic send_vec(input logic [5:0] v, input logic md, input logic [5:0] exp);
    int cnt = 0;
    wait_ready();
    io.vec_valid = 1'b1;
    io.vec_data  = v;
    io.vec_mode  = md;
    sb.push_back(exp);
    @(negedge clk);
    io.vec_valid = 1'b0;
    #1;
    check("busy_on_accept", 16'(io.busy), 16'd1);
    while (!io.res_valid && cnt < 40) begin @(negedge clk); #1; cnt++; end
    check("latency", 16'(cnt), 16'(N));
  endtask

  task automatic drain;
    int c = 0;
    while (sb.size() != 0 && c < 100) begin @(negedge clk); c++; end
    if (sb.size() != 0) check("drain", 16'(sb.size()), 16'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 6'b101101, 1'b0, 6'b101101};
    tbl[1] = '{1'b1, 6'b101101, 1'b1, 6'b101101};
    tbl[2] = '{1'b0, 6'b000111, 1'b0, 6'b111111};
    tbl[3] = '{1'b0, 6'b000111, 1'b1, 6'b111111};
    tbl[4] = '{1'b0, 6'b000011, 1'b0, 6'b000000};
    tbl[5] = '{1'b0, 6'b000011, 1'b1, 6'b111111};
    tbl[6] = '{1'b0, 6'b000000, 1'b0, 6'b000000};
    tbl[7] = '{1'b0, 6'b000000, 1'b1, 6'b000000};
    for (int i = 0; i < N; i++) m[i] = '0;

    io.load_valid = 1'b0; io.load_data = '0; io.load_clr = 1'b0;
    io.vec_valid  = 1'b0; io.vec_data  = '0; io.vec_mode = 1'b0;
    io.res_ready  = 1'b1;

    // Reset state
    #3;
    check("rst_res_valid", 16'(io.res_valid), 16'd0);
    check("rst_res_data", 16'(io.res_data), 16'd0);
    check("rst_load_row", 16'(io.load_row), 16'd0);
    check("rst_busy", 16'(io.busy), 16'd0);
    check("rst_load_ready", 16'(io.load_ready), 16'd1);
    check("rst_vec_ready", 16'(io.vec_ready), 16'd1);
    io.load_valid = 1'b1;
    #1;
    check("rst_vec_ready_ld", 16'(io.vec_ready), 16'd0);
    io.load_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table: identity then all-ones matrix
    begin
      int cur = -1;
      for (int i = 0; i < 8; i++) begin
        if (int'(tbl[i].ident) != cur) begin
          load_matrix(~tbl[i].ident);
          cur = int'(tbl[i].ident);
        end
        send_vec(tbl[i].vec, tbl[i].mode, tbl[i].exp);
      end
    end
    drain();

    // Pointer wrap and clear
    load_matrix(1'b0);
    #1 check("wrap_row6", 16'(io.load_row), 16'd0);
    do_load(6'b100001, 1'b0);
    #1 check("wrap_row7", 16'(io.load_row), 16'd1);
    send_vec(6'b000001, 1'b0, 6'b100001);
    send_vec(6'b000010, 1'b0, 6'b000010);
    @(negedge clk);
    io.load_clr = 1'b1;
    @(negedge clk);
    io.load_clr = 1'b0;
    ptr = 0;
    #1 check("clr_alone_row", 16'(io.load_row), 16'd0);
    do_load(6'b010010, 1'b1);
    #1 check("clr_load_row", 16'(io.load_row), 16'd1);
    send_vec(6'b000001, 1'b0, 6'b010010);
    drain();

    // Load and vector in the same IDLE cycle: load wins, vector follows
    @(negedge clk);
    io.load_valid = 1'b1; io.load_data = 6'b111000; io.load_clr = 1'b0;
    io.vec_valid  = 1'b1; io.vec_data  = 6'b000010; io.vec_mode = 1'b0;
    #1;
    check("sim_load_ready", 16'(io.load_ready), 16'd1);
    check("sim_vec_ready", 16'(io.vec_ready), 16'd0);
    @(negedge clk);
    io.load_valid = 1'b0;
    m[ptr] = 6'b111000; ptr = ptr + 1;
    #1;
    check("sim_vec_ready2", 16'(io.vec_ready), 16'd1);
    check("sim_load_row", 16'(io.load_row), 16'd2);
    sb.push_back(6'b111000);
    @(negedge clk);
    io.vec_valid = 1'b0;
    #1 check("sim_busy", 16'(io.busy), 16'd1);
    drain();

    // Backpressure: result held, pending vector refused until handshake
    io.res_ready = 1'b0;
    send_vec(6'b000100, 1'b0, 6'b000100);
    io.vec_valid = 1'b1; io.vec_data = 6'b000001; io.vec_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_res_valid", 16'(io.res_valid), 16'd1);
      check("bp_res_data", 16'(io.res_data), 16'b000100);
      check("bp_vec_ready", 16'(io.vec_ready), 16'd0);
      check("bp_load_ready", 16'(io.load_ready), 16'd0);
    end
    @(negedge clk);
    io.res_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_valid", 16'(io.res_valid), 16'd0);
    check("bp_release_vec_ready", 16'(io.vec_ready), 16'd1);
    sb.push_back(6'b010010);
    @(negedge clk);
    io.vec_valid = 1'b0;
    #1 check("bp_next_busy", 16'(io.busy), 16'd1);
    drain();

    // Random matrix against the model
    for (int r = 0; r < N; r++) do_load(6'($urandom), 1'b0);
    for (int r = 0; r < 4; r++) begin
      logic [5:0] v;
      v = 6'($urandom);
      send_vec(v, 1'b0, mv(v, 1'b0));
      send_vec(v, 1'b1, mv(v, 1'b1));
    end
    drain();

    // Reset in the middle of COMPUTE
    wait_ready();
    io.vec_valid = 1'b1; io.vec_data = 6'b111111; io.vec_mode = 1'b0;
    @(negedge clk);
    io.vec_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", 16'(io.res_valid), 16'd0);
    check("mid_rst_busy", 16'(io.busy), 16'd0);
    check("mid_rst_load_row", 16'(io.load_row), 16'd0);
    check("mid_rst_res_data", 16'(io.res_data), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) m[i] = '0;
    ptr = 0;
    send_vec(6'b111111, 1'b0, 6'b000000);
    send_vec(6'b111111, 1'b1, 6'b000000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_err);
    $finish;
  end
endmodule

// File: doc/bit_matvec_engine.md
# bit_matvec_engine

Parametrised successor to the team's 6x6 bit-matrix/vector multiplier. The block stores an N x N single-bit matrix that is loaded row by row over a valid/ready port. It multiplies an N-bit input vector by that matrix serially, one row per cycle, in either GF(2) (XOR-accumulate) or Boolean (OR-accumulate) mode. The result is presented on a valid/ready output that holds its value under backpressure. It sits between the tile's input register bank and the output pins, replacing the toggle-triggered fixed-size multiplier.

## Interface
Parameters:
- N, 6, matrix dimension and vector/result width; legal range 2..16
- RW, $clog2(N), width of the row pointer (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- load_valid  in  1  row write request
- load_ready  out  1  row write accepted when high with load_valid
- load_data  in  N  row contents; load_data[j] = M[row][j]
- load_clr  in  1  synchronous: forces the load pointer to 0 (takes priority over a same-cycle load)
- load_row  out  RW  row index the next accepted load writes
- vec_valid  in  1  vector request
- vec_ready  out  1  vector accepted when high with vec_valid
- vec_data  in  N  x; vec_data[i] selects row i
- vec_mode  in  1  sampled with the vector: 0 = XOR (GF(2)), 1 = OR
- res_valid  out  1  result available
- res_ready  in  1  result consumed when high with res_valid
- res_data  out  N  y[j]
- busy  out  1  high in COMPUTE or DONE

## Operation
- Function:
  - mode 0: y[j] = XOR over i of (x[i] & M[i][j]).
  - mode 1: y[j] = OR over i of the same terms.
  - Mode 0 equals the parity truncation of the legacy block.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - load_ready = 1.
  - vec_ready = ~load_valid. A load has priority over a vector in the same cycle.
  - On a vector handshake: latch x and mode, clear the accumulator, set k = 0, go to COMPUTE.
- Load handshake (IDLE only):
  - Write M[load_row] <= load_data.
  - load_row increments and wraps from N-1 to 0.
  - load_clr without load_valid sets load_row = 0.
  - load_clr with load_valid writes row 0, then sets load_row = 1.
- COMPUTE:
  - Each cycle: acc <= acc OP (x[k] ? M[k] : 0); k++.
  - After row N-1 has been folded in: res_data <= final acc, res_valid <= 1, go to DONE.
  - load_ready = 0, vec_ready = 0.
- DONE:
  - res_data and res_valid are held stable until res_ready.
  - On the handshake: res_valid <= 0, go to IDLE.
  - res_data keeps the last result until the next DONE entry.
- Loads during COMPUTE/DONE are refused (ready low); matrix contents are never modified mid-computation.
- Reset (any time, including mid-COMPUTE):
  - State = IDLE.
  - All matrix bits = 0.
  - load_row = 0, accumulator = 0, x = 0.
  - res_data = 0, res_valid = 0, busy = 0.
  - The in-flight operation is discarded.

## Timing
- Reset values of the registered outputs: res_valid 0, res_data 0, load_row 0, busy 0.
- Combinational outputs after reset: load_ready = 1, vec_ready = ~load_valid.
- Vector accepted at edge t:
  - busy is high from t.
  - res_valid is high after edge t+N.
  - Latency is N cycles.
- With res_ready held high:
  - The result handshake occurs at edge t+N+1.
  - vec_ready returns after t+N+1.
  - Maximum rate is one vector per N+2 cycles.
- A loaded row is visible to a vector accepted on the next edge or later.
- load_ready and vec_ready depend on state and load_valid only; there is no path from res_ready to the input readies.

## Test plan
- Identity load (row i = 1<<i, six loads, N=6), vec 6'b101101 in mode 0 and mode 1 -> res_data 6'b101101 in both modes; res_valid rises exactly 6 cycles after acceptance.
- All-ones matrix:
  - vec 6'b000111 -> mode 0: 6'b111111; mode 1: 6'b111111.
  - vec 6'b000011 -> mode 0: 6'b000000; mode 1: 6'b111111.
  - vec 0 -> 0 in both modes.
- Backpressure: res_ready low for 5 cycles after res_valid -> res_data stable, vec_ready and load_ready low, a pending vec_valid is not accepted; release -> handshake, then the vector is accepted on the next cycle.
- Pointer wrap / clear: 7 loads -> the 7th overwrites row 0, load_row = 1; then load_clr alone -> load_row = 0; load_clr with a load -> row 0 written, load_row = 1.
- Simultaneous load_valid and vec_valid in IDLE -> load accepted, vec_ready low that cycle; vector accepted the following cycle and its result uses the new row.
- rst_n pulsed low during cycle 3 of COMPUTE -> res_valid and busy 0 immediately, load_row 0; a subsequent vec 6'b111111 -> res_data 6'b000000 (matrix cleared).
